// File: rtl/cb_filter_pkg.sv
// Shared constants, FSM encoding and filter-threshold helper for the IO debounce scanner.
package cb_filter_pkg;

  localparam int DEF_OPT_NUM    = 40;
  localparam int DEF_IDX_W      = 6;
  localparam int DEF_CNT_W      = 4;
  localparam int DEF_PRESCALE_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  // A programmed threshold of 0 behaves like 1 so a channel can never be frozen.
  function automatic int unsigned norm_filter_cnt(input int unsigned raw);
    return (raw == 0) ? 32'd1 : raw;
  endfunction

endpackage

// File: rtl/cb_filter_scan_ctrl_if.sv
// Change-event port towards the CPU register block; valid/ready, fields held while valid.
interface cb_filter_scan_ctrl_if
  import cb_filter_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
);

  logic             chg_valid;
  logic [IDX_W-1:0] chg_idx;
  logic             chg_level;
  logic             chg_ready;

  modport master (
    output chg_valid,
    output chg_idx,
    output chg_level,
    input  chg_ready
  );

  modport slave (
    input  chg_valid,
    input  chg_idx,
    input  chg_level,
    output chg_ready
  );

endinterface

// File: rtl/cb_scan_prescaler.sv
// Scan-tick generator: tick every cfg_prescale+1 cycles while enabled, combinational from the count.
// Ticks landing on a busy scanner are dropped and latched in the sticky overrun flag.
module cb_scan_prescaler
  import cb_filter_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  cfg_en,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  scan_busy,
  input  logic                  ovf_clr,
  output logic                  tick,
  output logic                  ovf_o
);

  logic [PRESCALE_W-1:0] presc;

  assign tick = cfg_en && (presc == cfg_prescale);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      ovf_o <= 1'b0;
    end else begin
      if (!cfg_en || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
      // A new overrun outranks a simultaneous clear.
      if (tick && scan_busy) begin
        ovf_o <= 1'b1;
      end else if (ovf_clr) begin
        ovf_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cb_filter_scan_ctrl.sv
// Round-robin debounce of OPT_NUM synchronised inputs, one channel per cycle per scan tick.
// A commit that finds the event slot full and unaccepted parks the scan in STALL until chg_ready.
module cb_filter_scan_ctrl
  import cb_filter_pkg::*;
#(
  parameter int OPT_NUM    = DEF_OPT_NUM,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [OPT_NUM-1:0]    orign_opt_i,
  input  logic                  cfg_en,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic [CNT_W-1:0]      cfg_filter_cnt,
  input  logic                  ovf_clr,
  output logic [OPT_NUM-1:0]    filter_opt_o,
  cb_filter_scan_ctrl_if.master chg,
  output logic                  scan_busy,
  output logic                  ovf_o
);

  logic [OPT_NUM-1:0] sync1;
  logic [OPT_NUM-1:0] s_in;
  logic [CNT_W-1:0]   cnt [OPT_NUM];
  logic [1:0]         state;
  logic [IDX_W-1:0]   idx;
  logic               tick;
  logic               evt_valid;
  logic [IDX_W-1:0]   evt_idx;
  logic               evt_level;

  logic               ch_in;
  logic               differ;
  logic [CNT_W-1:0]   cnt_cur;
  logic [31:0]        cnt_inc;
  logic [31:0]        thr;
  logic               due;
  logic               blocked;
  logic               commit;
  logic               accept;
  logic               last_ch;

  assign scan_busy     = (state != ST_IDLE);
  assign chg.chg_valid = evt_valid;
  assign chg.chg_idx   = evt_idx;
  assign chg.chg_level = evt_level;

  cb_scan_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .cfg_en       (cfg_en),
    .cfg_prescale (cfg_prescale),
    .scan_busy    (scan_busy),
    .ovf_clr      (ovf_clr),
    .tick         (tick),
    .ovf_o        (ovf_o)
  );

  // Shared compare datapath for the channel currently addressed by idx.
  assign ch_in   = s_in[idx];
  assign differ  = (ch_in != filter_opt_o[idx]);
  assign cnt_cur = cnt[idx];
  assign cnt_inc = 32'(cnt_cur) + 32'd1;
  assign thr     = norm_filter_cnt(32'(cfg_filter_cnt));
  assign due     = (state == ST_SCAN) && differ && (cnt_inc >= thr);
  assign blocked = evt_valid && !chg.chg_ready;
  assign commit  = cfg_en && due && !blocked;
  assign accept  = evt_valid && chg.chg_ready;
  assign last_ch = (idx == IDX_W'(OPT_NUM - 1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      s_in  <= '0;
    end else begin
      sync1 <= orign_opt_i;
      s_in  <= sync1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else if (!cfg_en) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            idx   <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (due && blocked) begin
            state <= ST_STALL;
          end else if (last_ch) begin
            idx   <= '0;
            state <= ST_IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_STALL: begin
          if (chg.chg_ready) begin
            state <= ST_SCAN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A stalled compare leaves the counter untouched so the retry sees the same history.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OPT_NUM; i++) begin
        cnt[i] <= '0;
      end
    end else if (!cfg_en) begin
      for (int i = 0; i < OPT_NUM; i++) begin
        cnt[i] <= '0;
      end
    end else if (state == ST_SCAN) begin
      if (!differ) begin
        cnt[idx] <= '0;
      end else if (due) begin
        if (!blocked) begin
          cnt[idx] <= '0;
        end
      end else if (cnt_cur != {CNT_W{1'b1}}) begin
        cnt[idx] <= cnt_cur + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      filter_opt_o <= '0;
    end else if (commit) begin
      filter_opt_o[idx] <= ch_in;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      evt_level <= 1'b0;
    end else if (commit) begin
      evt_valid <= 1'b1;
      evt_idx   <= idx;
      evt_level <= ch_in;
    end else if (accept) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: doc/cb_filter_scan_ctrl.md
Name: cb_filter_scan_ctrl

Overview:
- Time-multiplexed IO debounce scheduler for the photoelectric input bank.
- One shared compare/count datapath is swept round-robin across all OPT_NUM channels on a programmable scan tick, replacing per-bit filter instances.
- Each committed level change is reported to the NIOS II side through a valid/ready event port.
- Sits between the raw IO pins and the CPU-facing IO register block.

Parameters:
- OPT_NUM, 40, number of input channels.
- IDX_W, 6, channel index width; must satisfy 2^IDX_W >= OPT_NUM.
- CNT_W, 4, per-channel debounce counter width.
- PRESCALE_W, 16, scan-tick prescaler width.

Ports:
- sys_clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- orign_opt_i  in  OPT_NUM  raw asynchronous IO inputs.
- cfg_en  in  1  scanning enable.
- cfg_prescale  in  PRESCALE_W  scan tick period = cfg_prescale+1 sys_clk cycles.
- cfg_filter_cnt  in  CNT_W  consecutive disagreeing scans required to commit; 0 is treated as 1.
- ovf_clr  in  1  clears ovf_o.
- filter_opt_o  out  OPT_NUM  debounced levels.
- chg_valid  out  1  change event pending.
- chg_idx  out  IDX_W  channel of the pending event.
- chg_level  out  1  new level of the pending event.
- chg_ready  in  1  consumer accepts the event.
- scan_busy  out  1  high while FSM is not IDLE.
- ovf_o  out  1  sticky: scan tick arrived while a scan was still running.

Behaviour:
- Reset: all outputs 0; all channel counters 0; prescaler 0; FSM IDLE; synchroniser flops 0.
- Input sync: 2-FF synchroniser per bit. The synchronised vector s_in is what the datapath samples.
- Prescaler: increments when cfg_en=1. When it equals cfg_prescale, tick=1 for one cycle and the prescaler returns to 0. With cfg_prescale=0, tick fires every cycle.
- FSM IDLE: on tick, load idx=0 and go to SCAN.
- FSM SCAN: processes channel idx in one cycle.
  - s_in[idx]==filter_opt_o[idx]: cnt[idx]<=0.
  - Otherwise, if cnt[idx]+1 >= max(cfg_filter_cnt,1): commit. filter_opt_o[idx]<=s_in[idx], cnt[idx]<=0, load an event (chg_valid=1, chg_idx=idx, chg_level=s_in[idx]).
  - Otherwise, cnt[idx]<=cnt[idx]+1, saturating at all-ones.
  - After processing idx, increment it. After idx=OPT_NUM-1, go to IDLE.
- Stall: if a commit is due while chg_valid=1 and chg_ready=0, go to STALL. Nothing is committed, idx is held, and counters are unchanged.
- FSM STALL: when chg_ready=1, re-evaluate channel idx next cycle in SCAN.
- Event slot: chg_valid clears on chg_valid&chg_ready. A commit in the same cycle as acceptance is allowed: the slot reloads and chg_valid stays 1. Event fields are stable while chg_valid=1.
- Overrun: tick while FSM != IDLE sets ovf_o and the tick is dropped. ovf_clr clears ovf_o; a set in the same cycle wins.
- cfg_en=0:
  - FSM goes to IDLE next cycle and the in-progress scan is aborted.
  - Prescaler and all cnt are cleared.
  - filter_opt_o holds, and a pending event is kept until accepted.
- Latency: a stable input change appears on filter_opt_o after 2 sync cycles plus cfg_filter_cnt scan ticks, plus the channel position within the scan.
- cfg_* changes are sampled live and take effect at the next compare; software changes them only while cfg_en=0.
- Async reset mid-scan returns everything to reset values immediately.

Decomposition:
- Package cb_filter_pkg holds:
  - FSM state encoding (IDLE, SCAN, STALL);
  - the filter_cnt zero-to-one normalisation function;
  - default constants for OPT_NUM, IDX_W, CNT_W, PRESCALE_W.
- One sub-module, cb_scan_prescaler: prescaler plus tick generation plus overrun flag.
- Counter array and FSM stay in the top module.

Test Plan:
- Basic commit: OPT_NUM=40, cfg_prescale=9, cfg_filter_cnt=3, chg_ready=1, raise bit 5 and hold. Expect filter_opt_o[5]=1 on the 3rd scan that sees it; exactly one event with chg_idx=5, chg_level=1; all other bits remain 0.
- Glitch rejection: same configuration, bit 12 high for 2 scans then low. Expect no event, filter_opt_o[12]=0, cnt[12] back to 0.
- Stall: chg_ready=0, bits 3 and 7 change together. Expect event idx=3, FSM enters STALL at idx 7, scan_busy=1. Raise chg_ready for one cycle: expect event idx=7 on the following cycles, then the scan completes.
- Overrun: cfg_prescale=20 (scan needs 40 cycles). Expect ovf_o=1 after the 2nd tick. Pulse ovf_clr: expect 0 until the next overlapping tick.
- cfg_filter_cnt=0: single-scan change on bit 39 commits on the first scan; event idx=39.
- Disable mid-scan: drop cfg_en at idx 20. Expect FSM IDLE next cycle, all cnt=0, filter_opt_o unchanged, pending event retained until chg_ready.
